instr_encoder_loader: RTL and testbench
=======================================

# instr_encoder_loader

Encodes field-level MIPS instruction descriptions (format + opcode/rs/rt/rd/shamt/func/immed/target) into 32-bit instruction words and writes them sequentially into instruction memory. It is the encoding counterpart of the pipeline's instruction decoder and sits between a test/boot source and the IMEM write port. It holds the core stalled until the program is fully loaded.

## Interface
Parameters:
- ADDR_W, 8, IMEM word-address width
- DEPTH, 256, IMEM depth in words (≤ 2^ADDR_W)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  begin a load session (sampled in IDLE/DONE)
- in_valid  in  1  instruction descriptor valid
- in_ready  out  1  loader can accept a descriptor
- fmt  in  2  0=R, 1=I, 2=J, 3=RAW
- opcode  in  6; rs, rt, rd, shamt  in  5 each; func  in  6
- immed  in  16; target  in  26; raw  in  32  (raw word for fmt 3)
- last  in  1  descriptor is the final instruction of the program
- imem_we  out  1  IMEM write strobe
- imem_addr  out  ADDR_W  IMEM word address
- imem_wdata  out  32  encoded instruction
- core_hold  out  1  stall/reset-hold for the pipeline
- done  out  1  load complete
- count  out  ADDR_W+1  words written this session
- overflow  out  1  program exceeded DEPTH

## Operation
- Encoding: R = {opcode,rs,rt,rd,shamt,func}; I = {opcode,rs,rt,immed}; J = {opcode,target}; RAW = raw. Fields not used by a format are ignored.
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE: in_ready=0, core_hold=1. start → LOAD. Address counter and count cleared, overflow cleared.
- LOAD: in_ready=1. Each handshake (in_valid & in_ready) registers encoded word and current address. The address then increments.
  - last=1 → DRAIN.
  - Handshake at address DEPTH-1 with last=0 → word written, overflow set, → DRAIN.
  - start ignored.
- DRAIN: in_ready=0; final write completes → DONE.
- DONE: done=1, core_hold=0, in_ready=0. start → LOAD (counters/overflow cleared, core_hold reasserted next cycle).
- in_valid outside LOAD is ignored and never written.
- Reset (any time, including mid-load) → IDLE immediately. Outputs take reset values; a partially loaded IMEM is not erased.

## Timing
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_hold=1, done=0, count=0, overflow=0.
- Write latency 1: handshake at edge N → imem_we=1 with addr/wdata during cycle N+1 (single-cycle strobe per word). count increments at the same edge.
- Back-to-back handshakes give one write per cycle, with consecutive addresses.
- Last handshake at edge N → DRAIN in cycle N+1 (final imem_we), DONE in cycle N+2. done=1 and core_hold=0 from N+2.
- start in DONE at edge M → LOAD in M+1, in_ready=1 and core_hold=1 in M+1.
- All outputs registered. No combinational path from inputs to outputs.

## Structure
- Shared package `mips_isa_pkg`:
  - fmt codes (FMT_R/I/J/RAW)
  - field bit positions (OPC_MSB=31, RS 25:21, RT 20:16, RD 15:11, SHAMT 10:6, FUNC 5:0, IMM 15:0, TGT 25:0)
  - loader state enum
- The decoder uses the same field positions from this package.
- Sub-module: `instr_field_packer`, a combinational fmt+fields → 32-bit word encoder. The FSM, counters and output registers live in the top module.

## Test plan
- R-format: fmt=0, opcode=0, rs=1, rt=2, rd=3, shamt=0, func=0x20, last=1 → one write, addr 0, wdata 0x00221820. done=1 two cycles after handshake, count=1.
- I and J formats: I with opcode=0x23, rs=29, rt=8, immed=0xFFFC, then J with opcode=2, target=0x0100000, last=1 → writes 0x8FA8FFFC at addr 0, then 0x08100000 at addr 1.
- Back-to-back: 4 consecutive RAW words 0x11111111..0x44444444 → four consecutive imem_we cycles, addr 0..3, count=4, then core_hold=0.
- Stalls and spurious valid: gaps in in_valid produce no writes. in_valid in IDLE or DONE causes no write and in_ready=0.
- Overflow: DEPTH=4, 5 descriptors without last → writes to addr 0..3, overflow=1, DONE, the 5th descriptor is never accepted.
- Reset mid-load after 2 words → immediate IDLE, core_hold=1, count=0. A new start reloads from addr 0.

Source files
------------

// File: rtl/mips_isa_pkg.sv
// MIPS instruction-format codes, field bit positions and loader states
// shared by the instruction encoder/loader and the pipeline decoder.
package mips_isa_pkg;

    typedef enum logic [1:0] {
        FMT_R   = 2'd0,
        FMT_I   = 2'd1,
        FMT_J   = 2'd2,
        FMT_RAW = 2'd3
    } fmt_e;

    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_MSB = 10;
    localparam int SHAMT_LSB = 6;
    localparam int FUNC_MSB  = 5;
    localparam int FUNC_LSB  = 0;
    localparam int IMM_MSB   = 15;
    localparam int IMM_LSB   = 0;
    localparam int TGT_MSB   = 25;
    localparam int TGT_LSB   = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_e;

endpackage

// File: rtl/instr_field_packer.sv
// Combinational encoder: instruction format plus fields to a 32-bit word.
module instr_field_packer
    import mips_isa_pkg::*;
(
    input  logic [1:0]  i_fmt,
    input  logic [5:0]  i_opcode,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_shamt,
    input  logic [5:0]  i_func,
    input  logic [15:0] i_immed,
    input  logic [25:0] i_target,
    input  logic [31:0] i_raw,
    output logic [31:0] o_word
);

    always_comb begin
        o_word = '0;
        unique case (fmt_e'(i_fmt))
            FMT_R: begin
                o_word[OPC_MSB:OPC_LSB]     = i_opcode;
                o_word[RS_MSB:RS_LSB]       = i_rs;
                o_word[RT_MSB:RT_LSB]       = i_rt;
                o_word[RD_MSB:RD_LSB]       = i_rd;
                o_word[SHAMT_MSB:SHAMT_LSB] = i_shamt;
                o_word[FUNC_MSB:FUNC_LSB]   = i_func;
            end
            FMT_I: begin
                o_word[OPC_MSB:OPC_LSB] = i_opcode;
                o_word[RS_MSB:RS_LSB]   = i_rs;
                o_word[RT_MSB:RT_LSB]   = i_rt;
                o_word[IMM_MSB:IMM_LSB] = i_immed;
            end
            FMT_J: begin
                o_word[OPC_MSB:OPC_LSB] = i_opcode;
                o_word[TGT_MSB:TGT_LSB] = i_target;
            end
            FMT_RAW: begin
                o_word = i_raw;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes instruction descriptors and writes them sequentially into IMEM,
// holding the core stalled until the program is fully loaded.
module instr_encoder_loader
    import mips_isa_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        fmt,
    input  logic [5:0]        opcode,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        func,
    input  logic [15:0]       immed,
    input  logic [25:0]       target,
    input  logic [31:0]       raw,
    input  logic              last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    loader_state_e     r_state;
    loader_state_e     w_next;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_ovf;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_in_ready;
    logic              r_core_hold;
    logic              r_done;
    logic [31:0]       w_word;
    logic              w_hs;
    logic              w_at_end;
    logic              w_clear;

    instr_field_packer u_packer (
        .i_fmt    (fmt),
        .i_opcode (opcode),
        .i_rs     (rs),
        .i_rt     (rt),
        .i_rd     (rd),
        .i_shamt  (shamt),
        .i_func   (func),
        .i_immed  (immed),
        .i_target (target),
        .i_raw    (raw),
        .o_word   (w_word)
    );

    assign w_hs     = in_valid && (r_state == ST_LOAD);
    assign w_at_end = (r_ptr == LAST_ADDR);
    assign w_clear  = (r_state == ST_IDLE) ||
                      ((r_state == ST_DONE) && start);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (w_hs && (last || w_at_end)) w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                w_next = ST_DONE;
            end
            ST_DONE: begin
                if (start) w_next = ST_LOAD;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up
    // with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_ready  <= 1'b0;
            r_core_hold <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            r_in_ready  <= (w_next == ST_LOAD);
            r_core_hold <= (w_next != ST_DONE);
            r_done      <= (w_next == ST_DONE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_ptr   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_we <= w_hs;
            if (w_hs) begin
                r_addr  <= r_ptr;
                r_wdata <= w_word;
                r_ptr   <= r_ptr + 1'b1;
                r_count <= r_count + 1'b1;
                if (w_at_end && !last) r_ovf <= 1'b1;
            end else if (w_clear) begin
                r_ptr   <= '0;
                r_count <= '0;
                r_ovf   <= 1'b0;
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign core_hold  = r_core_hold;
    assign done       = r_done;
    assign count      = r_count;
    assign overflow   = r_ovf;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed self-checking bench for instr_encoder_loader (DEPTH=4).
module tb_instr_encoder_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        fmt;
    logic [5:0]        opcode;
    logic [4:0]        rs, rt, rd, shamt;
    logic [5:0]        func;
    logic [15:0]       immed;
    logic [25:0]       target;
    logic [31:0]       raw;
    logic              last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_hold;
    logic              done;
    logic [ADDR_W:0]   count;
    logic              overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_n = 0;
    int accepted = 0;
    logic [ADDR_W-1:0] wr_addr [0:15];
    logic [31:0]       wr_data [0:15];
    int                wr_cyc  [0:15];

    instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fmt        (fmt),
        .opcode     (opcode),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .shamt      (shamt),
        .func       (func),
        .immed      (immed),
        .target     (target),
        .raw        (raw),
        .last       (last),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .done       (done),
        .count      (count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write log, sampled mid-cycle
    always @(negedge clk) begin
        if (imem_we && wr_n < 16) begin
            wr_addr[wr_n] = imem_addr;
            wr_data[wr_n] = imem_wdata;
            wr_cyc[wr_n]  = cyc;
            wr_n = wr_n + 1;
        end
    end

    task automatic send(input logic [1:0] f, input logic [5:0] op,
                        input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] d, input logic [4:0] sh,
                        input logic [5:0] fn, input logic [15:0] im,
                        input logic [25:0] tg, input logic [31:0] rw,
                        input logic lst);
        @(negedge clk);
        fmt = f; opcode = op; rs = s; rt = t; rd = d; shamt = sh;
        func = fn; immed = im; target = tg; raw = rw; last = lst;
        in_valid = 1'b1;
        if (in_ready) accepted = accepted + 1;
        @(posedge clk);
    endtask

    task automatic send_raw(input logic [31:0] rw, input logic lst);
        send(2'd3, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, rw, lst);
    endtask

    task automatic drop;
        @(negedge clk);
        in_valid = 1'b0;
        last = 1'b0;
    endtask

    task automatic start_session;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL rst_in_ready got %b want 0", in_ready);
        end
        checks++;
        if (imem_we !== 1'b0 || imem_addr !== '0 || imem_wdata !== '0) begin
            errors++;
            $display("FAIL rst_imem got we=%b a=%0d d=%h want 0/0/0",
                     imem_we, imem_addr, imem_wdata);
        end
        checks++;
        if (core_hold !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_status got hold=%b done=%b want 1/0",
                     core_hold, done);
        end
        checks++;
        if (count !== '0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL rst_count got cnt=%0d ovf=%b want 0/0",
                     count, overflow);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || core_hold !== 1'b1) begin
            errors++;
            $display("FAIL idle_out got rdy=%b hold=%b want 0/1",
                     in_ready, core_hold);
        end
    endtask

    task automatic test_r_format;
        wr_n = 0;
        start_session();
        checks++;
        if (in_ready !== 1'b1 || core_hold !== 1'b1) begin
            errors++;
            $display("FAIL load_out got rdy=%b hold=%b want 1/1",
                     in_ready, core_hold);
        end
        send(2'd0, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'hABCD,
             26'h3FFFFFF, 32'hDEADBEEF, 1'b1);
        drop();
        checks++;
        if (imem_we !== 1'b1 || imem_addr !== 8'd0 ||
            imem_wdata !== 32'h00221820) begin
            errors++;
            $display("FAIL r_write got we=%b a=%0d d=%h want 1/0/00221820",
                     imem_we, imem_addr, imem_wdata);
        end
        checks++;
        if (done !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL r_drain got done=%b rdy=%b want 0/0",
                     done, in_ready);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || core_hold !== 1'b0 || count !== 9'd1 ||
            imem_we !== 1'b0) begin
            errors++;
            $display("FAIL r_done got done=%b hold=%b cnt=%0d we=%b want 1/0/1/0",
                     done, core_hold, count, imem_we);
        end
        checks++;
        if (wr_n !== 1) begin
            errors++; $display("FAIL r_nwrites got %0d want 1", wr_n);
        end
    endtask

    task automatic test_i_j;
        wr_n = 0;
        start_session();
        send(2'd1, 6'h23, 5'd29, 5'd8, 5'd31, 5'd31, 6'h3F, 16'hFFFC,
             26'd0, 32'd0, 1'b0);
        send(2'd2, 6'd2, 5'd7, 5'd7, 5'd7, 5'd7, 6'd7, 16'h1234,
             26'h0100000, 32'd0, 1'b1);
        drop();
        repeat (2) @(negedge clk);
        checks++;
        if (wr_n !== 2) begin
            errors++; $display("FAIL ij_nwrites got %0d want 2", wr_n);
        end else begin
            checks++;
            if (wr_addr[0] !== 8'd0 || wr_data[0] !== 32'h8FA8FFFC) begin
                errors++;
                $display("FAIL i_write got a=%0d d=%h want 0/8FA8FFFC",
                         wr_addr[0], wr_data[0]);
            end
            checks++;
            if (wr_addr[1] !== 8'd1 || wr_data[1] !== 32'h08100000) begin
                errors++;
                $display("FAIL j_write got a=%0d d=%h want 1/08100000",
                         wr_addr[1], wr_data[1]);
            end
        end
        checks++;
        if (count !== 9'd2 || done !== 1'b1) begin
            errors++;
            $display("FAIL ij_done got cnt=%0d done=%b want 2/1", count, done);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_d [0:3];
        exp_d[0] = 32'h11111111; exp_d[1] = 32'h22222222;
        exp_d[2] = 32'h33333333; exp_d[3] = 32'h44444444;
        wr_n = 0;
        start_session();
        for (int i = 0; i < 4; i++) send_raw(exp_d[i], i == 3);
        drop();
        repeat (2) @(negedge clk);
        checks++;
        if (wr_n !== 4) begin
            errors++; $display("FAIL b2b_nwrites got %0d want 4", wr_n);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wr_addr[i] !== ADDR_W'(i) || wr_data[i] !== exp_d[i] ||
                    wr_cyc[i] !== wr_cyc[0] + i) begin
                    errors++;
                    $display("FAIL b2b_write%0d got a=%0d d=%h c=%0d want %0d/%h/%0d",
                             i, wr_addr[i], wr_data[i], wr_cyc[i],
                             i, exp_d[i], wr_cyc[0] + i);
                end
            end
        end
        checks++;
        if (count !== 9'd4 || core_hold !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done got cnt=%0d hold=%b ovf=%b want 4/0/0",
                     count, core_hold, overflow);
        end
    endtask

    task automatic test_stall_spurious;
        wr_n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        raw = 32'hBADBAD00;
        fmt = 2'd3;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || wr_n !== 0 || done !== 1'b1) begin
            errors++;
            $display("FAIL done_spur got rdy=%b nwr=%0d done=%b want 0/0/1",
                     in_ready, wr_n, done);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || wr_n !== 0 || core_hold !== 1'b1) begin
            errors++;
            $display("FAIL idle_spur got rdy=%b nwr=%0d hold=%b want 0/0/1",
                     in_ready, wr_n, core_hold);
        end
        in_valid = 1'b0;
        start_session();
        send_raw(32'hA5A5A5A5, 1'b0);
        drop();
        repeat (3) @(negedge clk);
        checks++;
        if (wr_n !== 1 || imem_we !== 1'b0 || count !== 9'd1) begin
            errors++;
            $display("FAIL gap_nowrite got nwr=%0d we=%b cnt=%0d want 1/0/1",
                     wr_n, imem_we, count);
        end
        send_raw(32'h5A5A5A5A, 1'b1);
        drop();
        repeat (2) @(negedge clk);
        checks++;
        if (wr_n !== 2 || wr_addr[1] !== 8'd1 || wr_data[1] !== 32'h5A5A5A5A) begin
            errors++;
            $display("FAIL gap_second got nwr=%0d a=%0d d=%h want 2/1/5A5A5A5A",
                     wr_n, wr_addr[1], wr_data[1]);
        end
    endtask

    task automatic test_overflow;
        wr_n = 0;
        accepted = 0;
        start_session();
        for (int i = 0; i < 5; i++) send_raw(32'hC0DE0000 + i, 1'b0);
        drop();
        repeat (3) @(negedge clk);
        checks++;
        if (accepted !== 4 || wr_n !== 4) begin
            errors++;
            $display("FAIL ovf_accept got acc=%0d nwr=%0d want 4/4",
                     accepted, wr_n);
        end else begin
            checks++;
            if (wr_addr[3] !== 8'd3 || wr_data[3] !== 32'hC0DE0003) begin
                errors++;
                $display("FAIL ovf_lastwr got a=%0d d=%h want 3/C0DE0003",
                         wr_addr[3], wr_data[3]);
            end
        end
        checks++;
        if (overflow !== 1'b1 || done !== 1'b1 || count !== 9'd4) begin
            errors++;
            $display("FAIL ovf_state got ovf=%b done=%b cnt=%0d want 1/1/4",
                     overflow, done, count);
        end
        start_session();
        checks++;
        if (overflow !== 1'b0 || count !== 9'd0 || core_hold !== 1'b1 ||
            in_ready !== 1'b1) begin
            errors++;
            $display("FAIL restart got ovf=%b cnt=%0d hold=%b rdy=%b want 0/0/1/1",
                     overflow, count, core_hold, in_ready);
        end
        send_raw(32'h0, 1'b1);
        drop();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_midload;
        wr_n = 0;
        start_session();
        send_raw(32'h01010101, 1'b0);
        send_raw(32'h02020202, 1'b0);
        drop();
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (core_hold !== 1'b1 || count !== '0 || in_ready !== 1'b0 ||
            imem_we !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got hold=%b cnt=%0d rdy=%b we=%b done=%b want 1/0/0/0/0",
                     core_hold, count, in_ready, imem_we, done);
        end
        @(negedge clk);
        reset = 1'b0;
        wr_n = 0;
        start_session();
        send_raw(32'h03030303, 1'b1);
        drop();
        repeat (2) @(negedge clk);
        checks++;
        if (wr_n !== 1 || wr_addr[0] !== 8'd0 || count !== 9'd1 ||
            done !== 1'b1) begin
            errors++;
            $display("FAIL reload got nwr=%0d a=%0d cnt=%0d done=%b want 1/0/1/1",
                     wr_n, wr_addr[0], count, done);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; last = 1'b0;
        fmt = '0; opcode = '0; rs = '0; rt = '0; rd = '0; shamt = '0;
        func = '0; immed = '0; target = '0; raw = '0;
        test_reset();
        test_r_format();
        test_i_j();
        test_back_to_back();
        test_stall_spurious();
        test_overflow();
        test_reset_midload();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
